// File: rtl/mlx90640_subpage_scheduler_if.sv
// Pixel-address stream between the subpage scheduler and the per-pixel compensation pipeline.
interface mlx90640_subpage_scheduler_if #(
    parameter int ADDRW = 10
);
    logic             pix_valid;
    logic             pix_ready;
    logic [ADDRW-1:0] pix_addr;

    modport master (output pix_valid, output pix_addr, input pix_ready);
    modport slave  (input pix_valid, input pix_addr, output pix_ready);
endinterface

// File: rtl/mlx90640_subpage_scheduler.sv
// Walks the MLX90640 subpage pattern ROM pair once per start and streams, in ascending order,
// the pixel addresses whose pattern bit is set for the latched subpage.
module mlx90640_subpage_scheduler #(
    parameter int DEPTH    = 832,
    parameter int SCAN_LEN = 768,
    localparam int ADDRW   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        subpage,
    input  logic                        abort,
    output logic [ADDRW-1:0]            rom_addr,
    input  logic                        rom_pg0,
    input  logic                        rom_pg1,
    mlx90640_subpage_scheduler_if.master pix,
    output logic                        busy,
    output logic                        done,
    output logic [ADDRW-1:0]            pix_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SCAN_LEN - 1);
    localparam logic [ADDRW-1:0] ADDR_ONE  = ADDRW'(1);
    localparam logic [ADDRW-1:0] ADDR_ZERO = ADDRW'(0);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             sub_r;
    logic [ADDRW-1:0] issue_cnt_r;
    logic             in_flight_r;
    logic [ADDRW-1:0] flight_addr_r;
    logic [1:0]       occ_r;
    logic [1:0]       occ_nxt_s;
    logic [ADDRW-1:0] head_r;
    logic [ADDRW-1:0] head_nxt_s;
    logic [ADDRW-1:0] tail_r;
    logic [ADDRW-1:0] tail_nxt_s;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;
    logic [ADDRW-1:0] count_r;

    logic             start_acc_s;
    logic             pop_s;
    logic             ret_bit_s;
    logic             push_s;
    logic [2:0]       credit_s;
    logic             issue_en_s;
    logic             last_issue_s;
    logic             drained_s;

    assign rom_addr      = issue_cnt_r;
    assign pix.pix_valid = valid_r;
    assign pix.pix_addr  = head_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pix_count     = count_r;

    // Issue credit, ROM return qualification and FSM next state.
    always_comb begin
        start_acc_s = (state_r == ST_IDLE) & start & ~abort;
        pop_s       = valid_r & pix.pix_ready;
        ret_bit_s   = sub_r ? rom_pg1 : rom_pg0;
        push_s      = in_flight_r & ret_bit_s;
        // Counting this cycle's pop keeps one read in flight while the sink drains, so 1 pixel/clk holds.
        credit_s    = {2'b00, in_flight_r} + {1'b0, occ_r} - {2'b00, pop_s};
        if (state_r == ST_SCAN) begin
            issue_en_s = (credit_s < 3'd2);
        end else begin
            issue_en_s = 1'b0;
        end
        last_issue_s = issue_en_s & (issue_cnt_r == LAST_ADDR);
        drained_s    = ~in_flight_r & (occ_r == 2'd0);

        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_SCAN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (last_issue_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_DRAIN: begin
                    if (drained_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_DONE:  state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer next-state: head is the presented address, tail the overflow slot.
    always_comb begin
        occ_nxt_s  = occ_r;
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_r == 2'd0) begin
                    head_nxt_s = flight_addr_r;
                end else begin
                    tail_nxt_s = flight_addr_r;
                end
                occ_nxt_s = occ_r + 2'd1;
            end
            2'b01: begin
                head_nxt_s = tail_r;
                occ_nxt_s  = occ_r - 2'd1;
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    head_nxt_s = flight_addr_r;
                end else begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = flight_addr_r;
                end
                occ_nxt_s = occ_r;
            end
            default: begin
                occ_nxt_s = occ_r;
            end
        endcase
    end

    // FSM state and the busy/done flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sub_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
            if (start_acc_s) begin
                sub_r <= subpage;
            end else begin
                sub_r <= sub_r;
            end
        end
    end

    // Issue counter (drives rom_addr) and the one-deep record of the read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_r   <= ADDR_ZERO;
            in_flight_r   <= 1'b0;
            flight_addr_r <= ADDR_ZERO;
        end else if (abort) begin
            issue_cnt_r   <= ADDR_ZERO;
            in_flight_r   <= 1'b0;
            flight_addr_r <= flight_addr_r;
        end else begin
            in_flight_r   <= issue_en_s;
            flight_addr_r <= issue_cnt_r;
            if (start_acc_s) begin
                issue_cnt_r <= ADDR_ZERO;
            end else if (issue_en_s && !last_issue_s) begin
                issue_cnt_r <= issue_cnt_r + ADDR_ONE;
            end else begin
                issue_cnt_r <= issue_cnt_r;
            end
        end
    end

    // Skid buffer storage and the registered pix_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
            head_r  <= ADDR_ZERO;
            tail_r  <= ADDR_ZERO;
        end else if (abort) begin
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
            head_r  <= head_r;
            tail_r  <= tail_r;
        end else begin
            occ_r   <= occ_nxt_s;
            valid_r <= (occ_nxt_s != 2'd0);
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
        end
    end

    // Accepted-pixel counter; survives abort and done so software can read the last scan's total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ADDR_ZERO;
        end else if (abort) begin
            count_r <= count_r;
        end else if (start_acc_s) begin
            count_r <= ADDR_ZERO;
        end else if (pop_s) begin
            count_r <= count_r + ADDR_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_mlx90640_subpage_scheduler.sv
// Scoreboard bench: expected pixel lists come from a pattern model; a monitor checks each handshake.
module tb_mlx90640_subpage_scheduler;

    localparam int DEPTH    = 832;
    localparam int SCAN_LEN = 768;
    localparam int ADDRW    = 10;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             subpage;
    logic             abort;
    logic [ADDRW-1:0] rom_addr;
    logic             rom_pg0;
    logic             rom_pg1;
    logic             busy;
    logic             done;
    logic [ADDRW-1:0] pix_count;

    mlx90640_subpage_scheduler_if #(.ADDRW(ADDRW)) pix ();

    mlx90640_subpage_scheduler #(.DEPTH(DEPTH), .SCAN_LEN(SCAN_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .subpage(subpage), .abort(abort),
        .rom_addr(rom_addr), .rom_pg0(rom_pg0), .rom_pg1(rom_pg1), .pix(pix),
        .busy(busy), .done(done), .pix_count(pix_count)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int acc0 = 0;
    int accepted = 0;
    int mode = 0;          // 0 all-ones, 1 chess, 2 all-zero, 3 random
    bit chk_timing = 0;
    bit rnd_ready = 0;
    bit rnd0[DEPTH];
    bit rnd1[DEPTH];
    int exp_q[$];

    function automatic bit pat(input int a, input bit sp);
        bit even;
        even = ((((a / 32) ^ (a % 32)) & 1) == 0);
        case (mode)
            0: return 1'b1;
            1: return sp ? !even : even;
            2: return 1'b0;
            default: return sp ? rnd1[a] : rnd0[a];
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous ROM pair with one cycle of read latency.
    always @(posedge clk) begin
        rom_pg0 <= pat(int'(rom_addr), 1'b0);
        rom_pg1 <= pat(int'(rom_addr), 1'b1);
    end

    initial begin
        pix.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix.pix_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: compares every accepted pixel against the scoreboard and checks stall stability.
    initial begin
        bit prev_stall;
        int prev_addr;
        int e;
        prev_stall = 0;
        prev_addr  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_held", int'(pix.pix_valid), 1);
                    chk("stall_addr_held", int'(pix.pix_addr), prev_addr);
                end
                if (pix.pix_valid === 1'b1 && pix.pix_ready === 1'b1 && abort !== 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL pix_unexpected: got addr %0d, expected no output (cycle %0d)",
                                 pix.pix_addr, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_addr", int'(pix.pix_addr), e);
                    end
                    if (chk_timing) chk("pix_cycle", cyc - t0, 3 + (accepted - acc0));
                    accepted++;
                end
                prev_stall = (pix.pix_valid === 1'b1) && (pix.pix_ready !== 1'b1) && (abort !== 1'b1);
                prev_addr  = int'(pix.pix_addr);
            end
        end
    end

    task automatic build_exp(input bit sp);
        exp_q.delete();
        for (int a = 0; a < SCAN_LEN; a++) begin
            if (pat(a, sp)) exp_q.push_back(a);
        end
    endtask

    task automatic do_start(input bit sp);
        @(posedge clk);
        #1;
        start   = 1'b1;
        subpage = sp;
        t0      = cyc;
        acc0    = accepted;
    endtask

    task automatic run_scan(input bit sp, input bit timing, input bit inject, input bit start_on_done);
        int n_exp;
        bit got;
        build_exp(sp);
        n_exp      = exp_q.size();
        chk_timing = timing;
        do_start(sp);
        got = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            start = inject && (i == 50);
            if (inject && i == 50) subpage = ~sp;
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", int'(got), 1);
        if (timing) chk("done_cycle", cyc - t0, SCAN_LEN + 4);
        chk("busy_at_done", int'(busy), 1);
        chk("count_at_done", int'(pix_count), n_exp);
        chk("accepted_total", accepted - acc0, n_exp);
        chk("scoreboard_empty", exp_q.size(), 0);
        if (start_on_done) begin
            start   = 1'b1;
            subpage = ~sp;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("count_held", int'(pix_count), n_exp);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_valid", int'(pix.pix_valid), 0);
        end
        chk_timing = 0;
    endtask

    initial begin
        bit got;
        rst_n   = 1'b0;
        start   = 1'b0;
        subpage = 1'b0;
        abort   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rnd0[i] = ($urandom_range(0, 1) == 1);
            rnd1[i] = ($urandom_range(0, 1) == 1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_pix_valid", int'(pix.pix_valid), 0);
        chk("rst_pix_addr", int'(pix.pix_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pix_count", int'(pix_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full-rate all-ones scan with exact latency, plus a start landing on the done cycle.
        mode = 0;
        run_scan(1'b0, 1'b1, 1'b0, 1'b1);

        // Chess pattern, subpage 1 with an opposite-subpage start mid-scan, then subpage 0.
        mode = 1;
        run_scan(1'b1, 1'b0, 1'b1, 1'b0);
        run_scan(1'b0, 1'b0, 1'b0, 1'b0);

        mode = 0;
        rnd_ready = 1;
        run_scan(1'b0, 1'b0, 1'b0, 1'b0);

        mode = 2;
        rnd_ready = 0;
        run_scan(1'b0, 1'b0, 1'b0, 1'b0);

        mode = 3;
        rnd_ready = 1;
        run_scan(($urandom_range(0, 1) == 1), 1'b0, 1'b0, 1'b0);
        rnd_ready = 0;

        // Abort after 100 accepted pixels, then a fresh scan from address 0.
        mode = 0;
        build_exp(1'b0);
        do_start(1'b0);
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (accepted - acc0 >= 100) begin
                got = 1;
                break;
            end
        end
        chk("abort_reached_100", int'(got), 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(pix.pix_valid), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_count_kept", int'(pix_count), 100);
        chk("abort_accepted", accepted - acc0, 100);
        exp_q.delete();
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("post_abort_done", int'(done), 0);
            chk("post_abort_busy", int'(busy), 0);
        end
        run_scan(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a stalled scan.
        mode = 1;
        rnd_ready = 1;
        build_exp(1'b1);
        do_start(1'b1);
        repeat (200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_addr", int'(rom_addr), 0);
        chk("mid_rst_pix_valid", int'(pix.pix_valid), 0);
        chk("mid_rst_pix_addr", int'(pix.pix_addr), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_pix_count", int'(pix_count), 0);
        exp_q.delete();
        rnd_ready = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_scan(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
